// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   ZeroWord / RstEnable : common word and reset-level constants
//   InstAddrBus / InstBus : address and instruction widths
//   fetch_state_e        : fetch controller states
//   if_entry_t           : {pc, inst} pair held in the output queue
package inst_fetch_pkg;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        RstEnable   = 1'b1;
  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;

  typedef enum logic [1:0] {
    FetchBoot  = 2'd0,
    FetchRun   = 2'd1,
    FetchDrain = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } if_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with occupancy count and flush.
//   clk, rst  : clock, async active-high reset
//   flush     : empties the FIFO; wins over push/pop in the same cycle
//   push/wdata: write an entry (caller guarantees not full)
//   pop       : drop the head entry (caller guarantees not empty)
//   rdata     : head entry (undefined when count == 0)
//   count     : number of valid entries
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  assign rdata = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: consumers gate the head with count != 0.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit feeding the IF/ID register.
//   clk, rst          : clock, async active-high reset
//   stall_i           : IF/ID not accepting; head entry is held
//   branch_flag_i     : redirect fetch to branch_target_i (word aligned)
//   imem_req_o/addr_o : fetch request and word address (current pc)
//   imem_gnt_i        : request accepted this cycle
//   imem_rvalid_i/rdata_i : in-order fetch response
//   if_valid_o/pc_o/inst_o : head {pc, inst}; zeros (a NOP) when empty
// Queue entries plus outstanding fetches never exceed QDEPTH, so the
// output queue cannot overflow. After a redirect, responses to fetches
// issued before it are counted in drop and discarded on arrival.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_i,
  output logic                   imem_req_o,
  output logic [InstAddrBus-1:0] imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [InstBus-1:0]     imem_rdata_i,
  output logic                   if_valid_o,
  output logic [InstAddrBus-1:0] if_pc_o,
  output logic [InstBus-1:0]     if_inst_o
);
  localparam int        CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0] QD = QDEPTH[CW:0];

  fetch_state_e           state, state_nxt;
  logic [InstAddrBus-1:0] pc, pc_nxt;
  logic [CW-1:0]          outstanding, outstanding_nxt;
  logic [CW-1:0]          drop, drop_nxt;
  logic [CW-1:0]          qcount, unused_pcq_count;
  logic [CW:0]            occupancy;
  logic                   gnt_fire, rsp_live, drop_rsp, take_rsp, pop;
  logic [InstAddrBus-1:0] rsp_pc;
  if_entry_t              head, push_entry;
  logic [1:0]             unused_tgt_lo;

  assign unused_tgt_lo = branch_target_i[1:0];

  assign occupancy   = {1'b0, qcount} + {1'b0, outstanding};
  assign imem_req_o  = (state != FetchBoot) && (occupancy < QD);
  assign imem_addr_o = pc;
  assign gnt_fire    = imem_req_o && imem_gnt_i;

  assign rsp_live  = imem_rvalid_i && (drop == '0);
  assign drop_rsp  = imem_rvalid_i && (drop != '0);
  // A response landing in the redirect cycle is stale and never pushed.
  assign take_rsp  = rsp_live && !branch_flag_i;
  assign pop       = if_valid_o && !stall_i && !branch_flag_i;

  assign outstanding_nxt = outstanding + CW'(gnt_fire) - CW'(imem_rvalid_i);

  assign push_entry = '{pc: rsp_pc, inst: imem_rdata_i};

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop;
    if (branch_flag_i) begin
      pc_nxt   = {branch_target_i[31:2], 2'b00};
      // Every fetch still in flight after this cycle predates the
      // redirect, so all of them must be discarded.
      drop_nxt = outstanding_nxt;
    end else begin
      if (gnt_fire) pc_nxt = pc + 32'd4;
      if (drop_rsp) drop_nxt = drop - CW'(1);
    end
    unique case (state)
      FetchBoot:            state_nxt = FetchRun;
      FetchRun, FetchDrain: state_nxt = (drop_nxt != '0) ? FetchDrain : FetchRun;
      default:              state_nxt = FetchBoot;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state       <= FetchBoot;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      assert (!(imem_rvalid_i && outstanding == '0));
      state       <= state_nxt;
      pc          <= pc_nxt;
      outstanding <= outstanding_nxt;
      drop        <= drop_nxt;
    end
  end

  // {pc, inst} output queue.
  fetch_queue #(.W($bits(if_entry_t)), .DEPTH(QDEPTH)) u_outq (
    .clk   (clk),
    .rst   (rst),
    .flush (branch_flag_i),
    .push  (take_rsp),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .count (qcount)
  );

  // PCs of granted, not-yet-answered fetches. Stale fetches were flushed
  // from here on redirect, so only live responses pop it.
  fetch_queue #(.W(InstAddrBus), .DEPTH(QDEPTH)) u_pcq (
    .clk   (clk),
    .rst   (rst),
    .flush (branch_flag_i),
    .push  (gnt_fire),
    .wdata (pc),
    .pop   (rsp_live),
    .rdata (rsp_pc),
    .count (unused_pcq_count)
  );

  assign if_valid_o = (qcount != '0);
  assign if_pc_o    = if_valid_o ? head.pc   : ZeroWord;
  assign if_inst_o  = if_valid_o ? head.inst : ZeroWord;
endmodule
